// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    HIT   = 2'd2
  } state_e;

  // Width of a field able to hold the values 0..max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len) + 1;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear coincident with an
// increment leaves the count at one.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with runtime overlap selection.
// Optional match counter is built when SEQ_DET_COUNT_EN is defined.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] win_q, win_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] shift_win;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  assign eff_len   = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
  assign shift_win = {win_q[MAX_LEN-2:0], in_bit};
  assign fill_inc  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
      ovl_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      fill_q <= fill_d;
      ovl_q  <= ovl_d;
    end
  end

  // A config load wins over a same-cycle valid bit, which is dropped.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    ovl_d   = ovl_q;
    hit     = 1'b0;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = eff_len;
      ovl_d   = cfg_overlap;
      win_d   = '0;
      fill_d  = '0;
      state_d = (eff_len == '0) ? UNCFG : HUNT;
    end else begin
      unique case (state_q)
        UNCFG: state_d = UNCFG;
        HUNT, HIT: begin
          state_d = HUNT;
          if (in_valid) begin
            win_d  = shift_win;
            fill_d = fill_inc;
            if ((fill_inc == len_q) && (((shift_win ^ pat_q) & len_mask) == '0)) begin
              hit     = 1'b1;
              state_d = HIT;
              if (!ovl_q) begin
                fill_d = '0;
              end
            end
          end
        end
        default: state_d = UNCFG;
      endcase
    end
  end

  always_comb begin
    match = (state_q == HIT);
    armed = (state_q != UNCFG);
  end

`ifdef SEQ_DET_COUNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hit),
    .clr_i (cnt_clr),
    .cnt_o (match_count)
  );
`else
  logic unused_cnt;
  assign unused_cnt  = cnt_clr ^ hit;
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus randomized traffic against
// a bit-history reference model; two DUTs differ only in counter width.
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
`ifdef SEQ_DET_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               match_a, armed_a, match_b, armed_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .cnt_clr(cnt_clr), .match(match_a),
    .match_count(cnt_a), .armed(armed_a));

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .cnt_clr(cnt_clr), .match(match_b),
    .match_count(cnt_b), .armed(armed_b));

  always #5 clk = ~clk;

  // Reference model: history of bits accepted since the last config load,
  // and how many of them are still eligible to start a match.
  bit         m_armed, m_ovl, m_match;
  int         m_len;
  logic [7:0] m_pat;
  bit         hist[$];
  int         m_fresh;
  int         m_cnt_a, m_cnt_b;

  int n_pass  = 0;
  int n_total = 0;
  int pulses  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit tail_matches();
    if (m_fresh < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (hist[hist.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_ovl = 0; m_match = 0; m_len = 0; m_pat = '0;
    hist.delete(); m_fresh = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_edge();
    m_match = 0;
    if (cfg_load) begin
      m_len   = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      m_pat   = cfg_pattern;
      m_ovl   = cfg_overlap;
      m_armed = (m_len != 0);
      hist.delete();
      m_fresh = 0;
    end else if (m_armed && in_valid) begin
      hist.push_back(in_bit);
      m_fresh++;
      if (tail_matches()) begin
        m_match = 1;
        if (!m_ovl) m_fresh = 0;
      end
    end
    if (cnt_clr) begin
      m_cnt_a = m_match ? 1 : 0;
      m_cnt_b = m_match ? 1 : 0;
    end else if (m_match) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".match_a"}, 32'(match_a), 32'(m_match));
    chk({tag, ".match_b"}, 32'(match_b), 32'(m_match));
    chk({tag, ".armed"},   32'(armed_a), 32'(m_armed));
    chk({tag, ".cnt_a"},   32'(cnt_a),   COUNT_EN ? 32'(m_cnt_a) : 32'd0);
    chk({tag, ".cnt_b"},   32'(cnt_b),   COUNT_EN ? 32'(m_cnt_b) : 32'd0);
  endtask

  task automatic step(input string tag, input bit v, input bit b, input bit ld, input bit clr);
    in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    if (match_a) pulses++;
    check_all(tag);
    in_valid = 0; cfg_load = 0; cnt_clr = 0;
  endtask

  task automatic configure(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input bit ovl, input bit clr);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    step(tag, 0, 0, 1, clr);
    pulses = 0;
  endtask

  task automatic send(input string tag, input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(tag, 1, bits[i], 0, 0);
      for (int g = 0; g < gap && i > 0; g++) step(tag, 0, 0, 0, 0);
    end
  endtask

  initial begin
    model_reset();
    #3 rst = 0;
    #1;
    chk("rst_async_armed", 32'(armed_a), 32'd0);
    @(posedge clk); #1;
    chk("rst_match", 32'(match_a), 32'd0);
    chk("rst_cnt",   32'(cnt_a),   32'd0);
    chk("rst_armed", 32'(armed_b), 32'd0);
    rst = 1;

    step("uncfg_ignore", 1, 1, 0, 0);

    configure("t1", 8'b1110, 4'd4, 0, 1);
    send("t1", 16'b11111_01110, 10, 0);
    step("t1_tail", 0, 0, 0, 0);
    chk("t1_pulses", 32'(pulses), 32'd2);
    chk("t1_count",  32'(cnt_a), COUNT_EN ? 32'd2 : 32'd0);

    configure("t2o", 8'b1010, 4'd4, 1, 0);
    send("t2o", 16'b1010101, 7, 0);
    step("t2o_tail", 0, 0, 0, 0);
    chk("t2_ovl_pulses", 32'(pulses), 32'd2);

    configure("t2n", 8'b1010, 4'd4, 0, 0);
    send("t2n", 16'b1010101, 7, 0);
    step("t2n_tail", 0, 0, 0, 0);
    chk("t2_novl_pulses", 32'(pulses), 32'd1);

    configure("t3", 8'b1, 4'd1, 1, 1);
    send("t3", 16'b1111, 4, 0);
    step("t3_tail", 0, 0, 0, 0);
    chk("t3_pulses", 32'(pulses), 32'd4);
    chk("t3_count",  32'(cnt_a), COUNT_EN ? 32'd4 : 32'd0);

    configure("t4", 8'b1110, 4'd4, 0, 0);
    send("t4", 16'b1110, 4, 3);
    step("t4_tail", 0, 0, 0, 0);
    chk("t4_pulses", 32'(pulses), 32'd1);

    configure("t5", 8'b1110, 4'd4, 0, 0);
    send("t5", 16'b111, 3, 0);
    in_bit = 1'b0;
    step("t5_ld", 1, 0, 1, 0);
    send("t5", 16'b110, 3, 0);
    step("t5_tail", 0, 0, 0, 0);
    chk("t5_pulses", 32'(pulses), 32'd0);

    configure("t5z", 8'b1, 4'd0, 1, 0);
    send("t5z", 16'b1111, 4, 0);
    chk("t5z_armed",  32'(armed_a), 32'd0);
    chk("t5z_pulses", 32'(pulses), 32'd0);

    configure("t6", 8'b1, 4'd1, 1, 1);
    send("t6", 16'b11111, 5, 0);
    chk("t6_sat", 32'(cnt_b), COUNT_EN ? 32'd3 : 32'd0);
    in_bit = 1'b1;
    step("t6_clr", 1, 1, 0, 1);
    chk("t6_clr_hit", 32'(cnt_b), COUNT_EN ? 32'd1 : 32'd0);

    configure("t7", 8'b1110, 4'd4, 0, 0);
    send("t7", 16'b111, 3, 0);
    #3 rst = 0;
    #1;
    model_reset();
    chk("t7_armed_async", 32'(armed_a), 32'd0);
    chk("t7_match_async", 32'(match_a), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    step("t7_lone0", 1, 0, 0, 0);
    chk("t7_cnt", 32'(cnt_a), 32'd0);

    // Random traffic; short patterns dominate so matches actually occur.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 12))
                                                  : 4'($urandom_range(1, 3));
        cfg_overlap = 1'($urandom);
        step("rnd_cfg", 1'($urandom), 1'($urandom), 1, $urandom_range(0, 30) == 0);
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, 1'($urandom), 0, $urandom_range(0, 60) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
